l2_arbiter: RTL and testbench

- Two-requester arbiter that shares the single unified L2 cache port between the I-cache miss path and the D-cache miss/writeback path.
- Sits between the split L1 caches and L2, and handles 128-bit line transfers.
- Serves one L1 transaction at a time and latches its request on grant.
- Round-robin on simultaneous requests.
- Keeps saturating performance counters, clearable by the pipeline's counter-reset control.

---
 rtl/l2_arbiter.sv | 169 ++++++++++++++++
 tb/tb_l2_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter
// Shares the single unified L2 port between the I-cache miss path and the
// D-cache miss/writeback path. One 128-bit line transaction is in flight at
// a time. Simultaneous requests alternate round-robin.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   icache_read/_address        I-cache line read request (held until resp)
//   icache_rdata/_resp          line returned to I-cache, completion pulse
//   dcache_read/_write/_address/_wdata   D-cache read or writeback request
//   dcache_rdata/_resp          line returned to D-cache, completion pulse
//   l2_read/_write/_address/_wdata       command to L2 (registered)
//   l2_rdata/_resp              L2 read line and completion pulse
//   clear_counters              synchronous clear of all counters
//   i_grant_count, d_grant_count, conflict_count   saturating counters
//   state_o                     debug view of the FSM state
//
// Handshake: an L1 request is a level held high until its resp pulse. The
// arbiter samples requests only in IDLE and latches op/address/wdata at the
// grant edge, so the L1 may change its inputs freely after that edge. The L2
// command stays asserted until the one-cycle l2_resp. resp is combinational
// with l2_resp, and the following IDLE cycle lets the finished requester
// drop its request before the next arbitration.
module l2_arbiter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 icache_read,
  input  logic [15:0]          icache_address,
  output logic [127:0]         icache_rdata,
  output logic                 icache_resp,
  input  logic                 dcache_read,
  input  logic                 dcache_write,
  input  logic [15:0]          dcache_address,
  input  logic [127:0]         dcache_wdata,
  output logic [127:0]         dcache_rdata,
  output logic                 dcache_resp,
  output logic                 l2_read,
  output logic                 l2_write,
  output logic [15:0]          l2_address,
  output logic [127:0]         l2_wdata,
  input  logic [127:0]         l2_rdata,
  input  logic                 l2_resp,
  input  logic                 clear_counters,
  output logic [CNT_WIDTH-1:0] i_grant_count,
  output logic [CNT_WIDTH-1:0] d_grant_count,
  output logic [CNT_WIDTH-1:0] conflict_count,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  state_t                 state_q;
  logic                   last_served_q;
  logic                   l2_read_q;
  logic                   l2_write_q;
  logic [15:0]            l2_address_q;
  logic [127:0]           l2_wdata_q;
  logic [CNT_WIDTH-1:0]   i_cnt_q;
  logic [CNT_WIDTH-1:0]   d_cnt_q;
  logic [CNT_WIDTH-1:0]   conf_cnt_q;

  logic req_i;
  logic req_d;
  logic grant_i;
  logic grant_d;
  logic both_pending;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    req_i        = icache_read;
    req_d        = dcache_read | dcache_write;
    both_pending = req_i & req_d;
    // On a tie the requester not served last wins.
    grant_i = (state_q == IDLE) && req_i && (!req_d || (last_served_q == LAST_D));
    grant_d = (state_q == IDLE) && req_d && (!req_i || (last_served_q == LAST_I));
  end

  // Main FSM with registered L2 command; the command registers double as
  // the latched request and are zero whenever the FSM is in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_served_q <= LAST_D;
      l2_read_q     <= 1'b0;
      l2_write_q    <= 1'b0;
      l2_address_q  <= '0;
      l2_wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q       <= SERVE_I;
            last_served_q <= LAST_I;
            l2_read_q     <= 1'b1;
            l2_write_q    <= 1'b0;
            l2_address_q  <= icache_address;
            l2_wdata_q    <= '0;
          end else if (grant_d) begin
            state_q       <= SERVE_D;
            last_served_q <= LAST_D;
            // Read and write both high is illegal; treat it as a write.
            l2_read_q     <= ~dcache_write;
            l2_write_q    <= dcache_write;
            l2_address_q  <= dcache_address;
            l2_wdata_q    <= dcache_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            state_q      <= IDLE;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Counters: clear wins over any same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt_q    <= '0;
      d_cnt_q    <= '0;
      conf_cnt_q <= '0;
    end else if (clear_counters) begin
      i_cnt_q    <= '0;
      d_cnt_q    <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (grant_i) i_cnt_q <= sat_inc(i_cnt_q);
      if (grant_d) d_cnt_q <= sat_inc(d_cnt_q);
      if ((grant_i || grant_d) && both_pending) conf_cnt_q <= sat_inc(conf_cnt_q);
    end
  end

  always_comb begin
    l2_read        = l2_read_q;
    l2_write       = l2_write_q;
    l2_address     = l2_address_q;
    l2_wdata       = l2_wdata_q;
    // Completion is only recognised while a transaction is in flight.
    icache_resp    = (state_q == SERVE_I) && l2_resp;
    dcache_resp    = (state_q == SERVE_D) && l2_resp;
    icache_rdata   = l2_rdata;
    dcache_rdata   = l2_rdata;
    i_grant_count  = i_cnt_q;
    d_grant_count  = d_cnt_q;
    conflict_count = conf_cnt_q;
    state_o        = state_q;
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter. A CNT_WIDTH=16 instance carries most
// checks; a CNT_WIDTH=2 instance driven by the same inputs covers counter
// saturation.
module tb_l2_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_I    = 2'd1;
  localparam logic [1:0] S_D    = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         icache_read;
  logic [15:0]  icache_address;
  logic         dcache_read;
  logic         dcache_write;
  logic [15:0]  dcache_address;
  logic [127:0] dcache_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic         clear_counters;

  logic [127:0] icache_rdata, dcache_rdata, l2_wdata;
  logic         icache_resp, dcache_resp, l2_read, l2_write;
  logic [15:0]  l2_address;
  logic [15:0]  i_cnt, d_cnt, c_cnt;
  logic [1:0]   state;

  logic [127:0] icache_rdata2, dcache_rdata2, l2_wdata2;
  logic         icache_resp2, dcache_resp2, l2_read2, l2_write2;
  logic [15:0]  l2_address2;
  logic [1:0]   i_cnt2, d_cnt2, c_cnt2;
  logic [1:0]   state2;

  l2_arbiter #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .clear_counters(clear_counters),
    .i_grant_count(i_cnt), .d_grant_count(d_cnt), .conflict_count(c_cnt),
    .state_o(state)
  );

  l2_arbiter #(.CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata2), .icache_resp(icache_resp2),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata2), .dcache_resp(dcache_resp2),
    .l2_read(l2_read2), .l2_write(l2_write2), .l2_address(l2_address2),
    .l2_wdata(l2_wdata2), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .clear_counters(clear_counters),
    .i_grant_count(i_cnt2), .d_grant_count(d_cnt2), .conflict_count(c_cnt2),
    .state_o(state2)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard check
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    icache_read    = 1'b0;
    icache_address = '0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = '0;
    dcache_wdata   = '0;
    l2_rdata       = '0;
    l2_resp        = 1'b0;
    clear_counters = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [127:0] pat_a5;
  logic [127:0] wd1;
  logic [127:0] wd2;
  logic [1:0]   exp_st;

  initial begin
    pat_a5 = {16{8'hA5}};
    wd1    = {4{32'hDEAD_BEEF}};
    wd2    = {4{32'h1234_5678}};
    clear_inputs();

    // Reset state
    tick();
    check("rst_state", {126'd0, state}, {126'd0, S_IDLE});
    check("rst_l2_read", {127'd0, l2_read}, 128'd0);
    check("rst_l2_write", {127'd0, l2_write}, 128'd0);
    check("rst_l2_address", {112'd0, l2_address}, 128'd0);
    check("rst_counters", {80'd0, i_cnt, d_cnt, c_cnt}, 128'd0);
    rst_n = 1'b1;
    tick();

    // I-cache alone: l2_read high for 3 cycles, response on the third
    icache_read    = 1'b1;
    icache_address = 16'h1230;
    tick();
    check("i_alone_state", {126'd0, state}, {126'd0, S_I});
    check("i_alone_read_c1", {127'd0, l2_read}, 128'd1);
    check("i_alone_addr", {112'd0, l2_address}, 128'h1230);
    check("i_alone_dresp_c1", {127'd0, dcache_resp}, 128'd0);
    tick();
    check("i_alone_read_c2", {127'd0, l2_read}, 128'd1);
    check("i_alone_iresp_c2", {127'd0, icache_resp}, 128'd0);
    tick();
    l2_resp  = 1'b1;
    l2_rdata = pat_a5;
    settle();
    check("i_alone_read_c3", {127'd0, l2_read}, 128'd1);
    check("i_alone_iresp", {127'd0, icache_resp}, 128'd1);
    check("i_alone_irdata", icache_rdata, pat_a5);
    check("i_alone_dresp", {127'd0, dcache_resp}, 128'd0);
    icache_read = 1'b0;
    tick();
    l2_resp = 1'b0;
    settle();
    check("i_alone_read_done", {127'd0, l2_read}, 128'd0);
    check("i_alone_iresp_done", {127'd0, icache_resp}, 128'd0);
    check("i_alone_idle", {126'd0, state}, {126'd0, S_IDLE});
    check("i_alone_icnt", {112'd0, i_cnt}, 128'd1);

    // Simultaneous requests after reset: I first, D starts 2 cycles after resp
    clear_inputs();
    do_reset();
    icache_read    = 1'b1;
    icache_address = 16'h0100;
    dcache_write   = 1'b1;
    dcache_address = 16'h4000;
    dcache_wdata   = wd1;
    tick();
    check("sim_first_i", {126'd0, state}, {126'd0, S_I});
    check("sim_i_l2write", {127'd0, l2_write}, 128'd0);
    tick();
    l2_resp  = 1'b1;
    l2_rdata = 128'h77;
    settle();
    check("sim_iresp", {127'd0, icache_resp}, 128'd1);
    check("sim_dresp_during_i", {127'd0, dcache_resp}, 128'd0);
    icache_read = 1'b0;
    tick();
    l2_resp = 1'b0;
    settle();
    check("sim_m1_idle", {126'd0, state}, {126'd0, S_IDLE});
    check("sim_m1_nowrite", {127'd0, l2_write}, 128'd0);
    tick();
    check("sim_m2_write", {127'd0, l2_write}, 128'd1);
    check("sim_m2_addr", {112'd0, l2_address}, 128'h4000);
    check("sim_m2_wdata", l2_wdata, wd1);
    check("sim_icnt", {112'd0, i_cnt}, 128'd1);
    check("sim_dcnt", {112'd0, d_cnt}, 128'd1);
    check("sim_ccnt", {112'd0, c_cnt}, 128'd1);
    l2_resp = 1'b1;
    settle();
    check("sim_dresp", {127'd0, dcache_resp}, 128'd1);
    check("sim_iresp_during_d", {127'd0, icache_resp}, 128'd0);
    dcache_write = 1'b0;
    tick();
    l2_resp = 1'b0;

    // Round-robin across 4 transactions with both held
    clear_inputs();
    do_reset();
    icache_read    = 1'b1;
    icache_address = 16'h0AA0;
    dcache_read    = 1'b1;
    dcache_address = 16'h0DD0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_st = (k % 2 == 0) ? S_I : S_D;
      check($sformatf("rr_grant_%0d", k), {126'd0, state}, {126'd0, exp_st});
      check($sformatf("rr_addr_%0d", k), {112'd0, l2_address},
            (k % 2 == 0) ? 128'h0AA0 : 128'h0DD0);
      l2_resp  = 1'b1;
      l2_rdata = 128'(k + 32'h100);
      settle();
      check($sformatf("rr_iresp_%0d", k), {127'd0, icache_resp}, (k % 2 == 0) ? 128'd1 : 128'd0);
      check($sformatf("rr_dresp_%0d", k), {127'd0, dcache_resp}, (k % 2 == 0) ? 128'd0 : 128'd1);
      tick();
      l2_resp = 1'b0;
      settle();
      check($sformatf("rr_idle_%0d", k), {126'd0, state}, {126'd0, S_IDLE});
    end
    icache_read = 1'b0;
    dcache_read = 1'b0;
    check("rr_ccnt", {112'd0, c_cnt}, 128'd4);
    check("rr_icnt", {112'd0, i_cnt}, 128'd2);
    check("rr_dcnt", {112'd0, d_cnt}, 128'd2);
    tick();

    // Address/wdata stability after grant
    dcache_write   = 1'b1;
    dcache_address = 16'h0ABC;
    dcache_wdata   = wd1;
    tick();
    check("stab_state", {126'd0, state}, {126'd0, S_D});
    dcache_address = 16'hFFFF;
    dcache_wdata   = wd2;
    dcache_write   = 1'b0;
    tick();
    check("stab_addr", {112'd0, l2_address}, 128'h0ABC);
    check("stab_wdata", l2_wdata, wd1);
    check("stab_write", {127'd0, l2_write}, 128'd1);
    check("stab_read", {127'd0, l2_read}, 128'd0);
    l2_resp = 1'b1;
    settle();
    check("stab_dresp", {127'd0, dcache_resp}, 128'd1);
    tick();
    l2_resp = 1'b0;
    settle();
    check("stab_idle", {126'd0, state}, {126'd0, S_IDLE});

    // Reset mid-transaction, then a late l2_resp
    dcache_write   = 1'b1;
    dcache_address = 16'h2222;
    tick();
    check("rmid_write", {127'd0, l2_write}, 128'd1);
    rst_n = 1'b0;
    settle();
    check("rmid_write_drop", {127'd0, l2_write}, 128'd0);
    check("rmid_state", {126'd0, state}, {126'd0, S_IDLE});
    check("rmid_counters", {80'd0, i_cnt, d_cnt, c_cnt}, 128'd0);
    dcache_write = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    l2_resp = 1'b1;
    settle();
    check("late_iresp", {127'd0, icache_resp}, 128'd0);
    check("late_dresp", {127'd0, dcache_resp}, 128'd0);
    tick();
    l2_resp = 1'b0;
    settle();
    check("late_state", {126'd0, state}, {126'd0, S_IDLE});

    // Counters: 5 I grants saturate the 2-bit instance at 3
    clear_inputs();
    do_reset();
    icache_address = 16'h0040;
    for (int k = 0; k < 5; k++) begin
      icache_read = 1'b1;
      tick();
      l2_resp = 1'b1;
      icache_read = 1'b0;
      tick();
      l2_resp = 1'b0;
      tick();
    end
    check("sat_icnt_w2", {126'd0, i_cnt2}, 128'd3);
    check("sat_icnt_w16", {112'd0, i_cnt}, 128'd5);
    icache_read    = 1'b1;
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    check("clr_state", {126'd0, state}, {126'd0, S_I});
    check("clr_icnt_w2", {126'd0, i_cnt2}, 128'd0);
    check("clr_icnt_w16", {112'd0, i_cnt}, 128'd0);
    l2_resp     = 1'b1;
    icache_read = 1'b0;
    tick();
    l2_resp = 1'b0;
    tick();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
